// File: rtl/decode_arbiter4_if.sv
// Request/grant bundle between requesters and decode_arbiter4.
// The arbiter takes the slave side; the requester side takes master.
interface decode_arbiter4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    modport master (output req, input gnt, gnt_idx, gnt_valid, preempt);
    modport slave  (input req, output gnt, gnt_idx, gnt_valid, preempt);
endinterface

// File: rtl/decode_arbiter4.sv
// Four-way round-robin arbiter with bounded hold and forced rotation.
// Every output is a flop, so req never reaches an output combinationally.
module decode_arbiter4 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input logic           clk,
    input logic           rst_n,
    decode_arbiter4_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       preempt_q, preempt_d;

    logic [3:0] others;
    logic [2:0] win_idle, win_rot;
    logic       at_limit;

    // Returns {found, index} of the first set bit of r, scanning upward from start.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = start + 2'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;

        // The old owner is masked so a rotation can never hand the grant back to it.
        others   = bus.req & ~(4'b0001 << idx_q);
        win_idle = pick(bus.req, ptr_q);
        win_rot  = pick(others, idx_q + 2'd1);
        at_limit = (HOLD_LIM != 8'd0) && (hold_cnt_q == HOLD_LIM);

        case (state_q)
            IDLE: begin
                hold_cnt_d = 8'd0;
                if (win_idle[2]) begin
                    state_d    = GRANT;
                    idx_d      = win_idle[1:0];
                    hold_cnt_d = 8'd1;
                end
            end
            GRANT: begin
                if (!bus.req[idx_q]) begin
                    ptr_d = idx_q + 2'd1;
                    if (win_rot[2]) begin
                        idx_d      = win_rot[1:0];
                        hold_cnt_d = 8'd1;
                    end else begin
                        state_d    = IDLE;
                        hold_cnt_d = 8'd0;
                    end
                end else if (at_limit && (others != 4'b0000)) begin
                    ptr_d      = idx_q + 2'd1;
                    idx_d      = win_rot[1:0];
                    hold_cnt_d = 8'd1;
                    preempt_d  = 1'b1;
                end else if (!at_limit && (hold_cnt_q != 8'hFF)) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_valid_d = (state_d == GRANT);
        gnt_d       = gnt_valid_d ? (4'b0001 << idx_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            idx_q       <= 2'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.preempt   = preempt_q;
endmodule

// File: tb/tb_decode_arbiter4.sv
// Bench for decode_arbiter4: directed vector table, corner sequences,
// and a random run compared against an independent reference model.
module tb_decode_arbiter4;
    localparam int LIM = 4;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       pre;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    decode_arbiter4_if ia();
    decode_arbiter4_if ib();

    decode_arbiter4 #(.MAX_HOLD(LIM)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    decode_arbiter4 #(.MAX_HOLD(0))   dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    always #5 clk = ~clk;

    vec_t tbl[$];
    vec_t sb[$];

    // Reference model state
    bit m_busy;
    int m_owner, m_ptr, m_cnt;

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i,
                       input logic v, input logic p);
        vec_t e;
        e.req = r; e.gnt = g; e.idx = i; e.valid = v; e.pre = p;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic [3:0] g, input logic [1:0] i,
                             input logic v, input logic p, input vec_t e);
        checks++;
        if (g !== e.gnt || v !== e.valid || p !== e.pre || (e.valid && i !== e.idx)) begin
            failures++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b preempt=%b expected gnt=%b idx=%0d valid=%b preempt=%b",
                     nm, g, i, v, p, e.gnt, e.idx, e.valid, e.pre);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int p);
        for (int s = 0; s < 4; s++) begin
            if (r[(p + s) % 4]) return (p + s) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, output vec_t e);
        int  w;
        bit  pre;
        logic [3:0] rest;
        pre = 1'b0;
        if (!m_busy) begin
            w = search(r, m_ptr);
            if (w >= 0) begin m_busy = 1'b1; m_owner = w; m_cnt = 1; end
        end else begin
            rest = r & ~(4'b0001 << m_owner);
            if (!r[m_owner] || (m_cnt >= LIM && rest != 4'b0000)) begin
                pre   = r[m_owner];
                m_ptr = (m_owner + 1) % 4;
                w     = search(rest, m_ptr);
                if (w < 0) begin m_busy = 1'b0; m_cnt = 0; end
                else begin m_owner = w; m_cnt = 1; end
            end else if (m_cnt < LIM) begin
                m_cnt++;
            end
        end
        e.req   = r;
        e.valid = m_busy;
        e.gnt   = m_busy ? 4'(1 << m_owner) : 4'b0000;
        e.idx   = 2'(m_owner);
        e.pre   = pre;
    endtask

    initial begin
        vec_t e;
        logic [3:0] r;
        int wait_k[4];
        int run;
        bit prev_v;
        logic [1:0] prev_idx;

        rst_n = 1'b0;
        ia.req = 4'b0000;
        ib.req = 4'b0000;

        // Rotation under full load, then release, bubble-free handoff, saturated hold.
        repeat (4) add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1);
        repeat (3) add(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1);
        repeat (3) add(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1);
        repeat (3) add(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        repeat (3) add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        repeat (6) add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        e.gnt = 4'b0000; e.idx = 2'd0; e.valid = 1'b0; e.pre = 1'b0; e.req = 4'b0000;
        check_out("reset_a", ia.gnt, ia.gnt_idx, ia.gnt_valid, ia.preempt, e);
        chk("reset_idx_a", int'(ia.gnt_idx), 0);
        check_out("reset_b", ib.gnt, ib.gnt_idx, ib.gnt_valid, ib.preempt, e);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            ia.req = tbl[i].req;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_out($sformatf("vec%0d", i), ia.gnt, ia.gnt_idx, ia.gnt_valid, ia.preempt, e);
        end

        // A request that rises and falls between edges is never seen.
        @(negedge clk);
        ia.req = 4'b0001;
        #2 ia.req = 4'b0000;
        @(posedge clk);
        #1;
        chk("glitch_gnt", int'(ia.gnt), 0);
        chk("glitch_valid", int'(ia.gnt_valid), 0);

        // Mid-grant asynchronous reset, then restart from ptr=0.
        @(negedge clk) ia.req = 4'b0100;
        @(posedge clk);
        #1;
        chk("pre_rst_gnt", int'(ia.gnt), 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        e.gnt = 4'b0000; e.idx = 2'd0; e.valid = 1'b0; e.pre = 1'b0;
        check_out("async_rst", ia.gnt, ia.gnt_idx, ia.gnt_valid, ia.preempt, e);
        chk("async_rst_idx", int'(ia.gnt_idx), 0);
        @(negedge clk);
        ia.req = 4'b0110;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        e.gnt = 4'b0010; e.idx = 2'd1; e.valid = 1'b1; e.pre = 1'b0;
        check_out("after_rst", ia.gnt, ia.gnt_idx, ia.gnt_valid, ia.preempt, e);

        // Unlimited hold: owner 0 keeps the grant indefinitely.
        @(negedge clk);
        ia.req = 4'b0000;
        ib.req = 4'b0011;
        e.gnt = 4'b0001; e.idx = 2'd0; e.valid = 1'b1; e.pre = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("nolimit%0d", c), ib.gnt, ib.gnt_idx, ib.gnt_valid, ib.preempt, e);
        end
        chk("hold_sat", int'(dut_b.hold_cnt_q), 255);
        @(negedge clk) ib.req = 4'b0000;

        // Random traffic against the model plus invariant checks.
        @(negedge clk) rst_n = 1'b0;
        ia.req = 4'b0000;
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        r = 4'b0000;
        for (int k = 0; k < 4; k++) wait_k[k] = 0;
        run = 0; prev_v = 1'b0; prev_idx = 2'd0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (r[k]) r[k] = ($urandom_range(0, 5) != 0);
                else      r[k] = ($urandom_range(0, 3) == 0);
            end
            ia.req = r;
            model_step(r, e);
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_out($sformatf("rand%0d", c), ia.gnt, ia.gnt_idx, ia.gnt_valid, ia.preempt, e);
            chk("onehot", ($countones(ia.gnt) > 1) ? 1 : 0, 0);
            if (ia.gnt_valid) chk("decode", int'(ia.gnt), int'(4'b0001 << ia.gnt_idx));
            if (ia.gnt_valid) begin
                if (!(prev_v && prev_idx == ia.gnt_idx)) run = 0;
                if ((r & ~(4'b0001 << ia.gnt_idx)) != 4'b0000) run++;
            end else begin
                run = 0;
            end
            chk("hold_limit", (run > LIM) ? run : 0, 0);
            prev_v = ia.gnt_valid;
            prev_idx = ia.gnt_idx;
            for (int k = 0; k < 4; k++) begin
                if (r[k] && !(ia.gnt_valid && ia.gnt_idx == 2'(k))) wait_k[k]++;
                else wait_k[k] = 0;
                if (wait_k[k] > 3 * LIM + 3) begin
                    chk($sformatf("starve%0d", k), wait_k[k], 3 * LIM + 3);
                    wait_k[k] = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
